// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: states,
// instruction classes, decode field constants and datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_JAL,
        CLS_BAD
    } iclass_t;

    // Opcodes
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // funct3 values
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Operand A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    // Operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    // PC source
    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

    // Write-back source
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // Immediate format
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU operation for the register/immediate arithmetic group, by funct3.
    function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3);
        logic [2:0] op;
        case (f3)
            F3_AND:  op = ALU_AND;
            F3_OR:   op = ALU_OR;
            F3_XOR:  op = ALU_XOR;
            F3_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_control_fsm_classify.sv
// Combinational instruction classifier: maps the instruction register to an
// instruction class and, for R/I arithmetic, the ALU operation to issue.
module instr_classify
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output iclass_t     iclass,
    output logic [2:0]  alu_op,
    output logic        br_ne
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alu_f3_ok;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register and immediate fields are datapath-only; the sequencer ignores them.
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // Only the arithmetic funct3 values with a matching ALU code are supported.
    assign alu_f3_ok = (funct3 == F3_ADD) || (funct3 == F3_AND) || (funct3 == F3_OR) ||
                       (funct3 == F3_XOR) || (funct3 == F3_SLT);

    // BNE differs from BEQ only in funct3 bit 0.
    assign br_ne = (funct3 == F3_BNE);

    // Decode opcode/funct fields into a class; anything unrecognised is BAD.
    always_comb begin
        iclass = CLS_BAD;
        alu_op = alu_from_funct3(funct3);
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE && alu_f3_ok) begin
                    iclass = CLS_R;
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    iclass = CLS_R;
                    alu_op = ALU_SUB;
                end
            end
            OP_I: begin
                if (alu_f3_ok) iclass = CLS_I;
            end
            OP_LW: begin
                if (funct3 == F3_LW) iclass = CLS_LW;
            end
            OP_SW: begin
                if (funct3 == F3_SW) iclass = CLS_SW;
            end
            OP_BR: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) iclass = CLS_BR;
            end
            OP_JAL: begin
                iclass = CLS_JAL;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control sequencer. Walks FETCH/DECODE/EXECUTE/MEM/WB,
// drives ALU and datapath strobes combinationally from the state and the
// instruction register, and traps permanently on unsupported encodings.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  imm_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal
);

    state_t     state;
    state_t     state_next;
    iclass_t    iclass;
    logic [2:0] cls_alu_op;
    logic       br_ne;
    logic       br_taken;

    instr_classify u_classify (
        .instr  (instr),
        .iclass (iclass),
        .alu_op (cls_alu_op),
        .br_ne  (br_ne)
    );

    // The compare result is used in the same cycle as the SUB that produces it.
    assign br_taken = br_ne ? !alu_zero : alu_zero;

    // State register; reset forces RESET immediately so every output drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RESET;
        else        state <= state_next;
    end

    // Next-state and output decode; everything not driven in a state stays 0.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_ctrl   = ALU_ADD;
        imm_sel    = IMM_I;
        reg_write  = 1'b0;
        wb_sel     = WB_ALUOUT;
        illegal    = 1'b0;

        case (state)
            ST_RESET: begin
                state_next = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                alu_ctrl  = ALU_ADD;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_ALU;
                    state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Branch/jump target is formed here so EXECUTE can load it from ALUOUT.
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                alu_ctrl  = ALU_ADD;
                if (iclass == CLS_BR)       imm_sel = IMM_B;
                else if (iclass == CLS_JAL) imm_sel = IMM_J;
                else                        imm_sel = IMM_I;
                state_next = (iclass == CLS_BAD) ? ST_TRAP : ST_EXECUTE;
            end

            ST_EXECUTE: begin
                case (iclass)
                    CLS_R: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_src_b  = SRC_B_RS2;
                        alu_ctrl   = cls_alu_op;
                        state_next = ST_WB;
                    end
                    CLS_I: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_src_b  = SRC_B_IMM;
                        imm_sel    = IMM_I;
                        alu_ctrl   = cls_alu_op;
                        state_next = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_src_b  = SRC_B_IMM;
                        imm_sel    = (iclass == CLS_SW) ? IMM_S : IMM_I;
                        alu_ctrl   = ALU_ADD;
                        state_next = ST_MEM;
                    end
                    CLS_BR: begin
                        alu_src_a = SRC_A_RS1;
                        alu_src_b = SRC_B_RS2;
                        alu_ctrl  = ALU_SUB;
                        if (br_taken) begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_ALUOUT;
                        end
                        state_next = ST_FETCH;
                    end
                    CLS_JAL: begin
                        // PC already holds the incremented address, i.e. the link value.
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_ALUOUT;
                        reg_write  = 1'b1;
                        wb_sel     = WB_PC;
                        state_next = ST_FETCH;
                    end
                    default: begin
                        state_next = ST_TRAP;
                    end
                endcase
            end

            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (iclass == CLS_SW);
                if (mem_ready) begin
                    state_next = (iclass == CLS_SW) ? ST_FETCH : ST_WB;
                end
            end

            ST_WB: begin
                reg_write  = 1'b1;
                wb_sel     = (iclass == CLS_LW) ? WB_MDR : WB_ALUOUT;
                state_next = ST_FETCH;
            end

            ST_TRAP: begin
                illegal    = 1'b1;
                state_next = ST_TRAP;
            end

            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control sequencer that drives the RV32I datapath and the shared 3-bit ALU. It issues `alu_ctrl`, operand selects and register/PC/memory strobes one state at a time. It decodes the instruction register and handshakes with a wait-state-capable unified memory, turning the combinational ALU into the execution stage of a multi-cycle core. Unsupported encodings trap and halt the core.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction register contents, valid from DECODE onward.
- `alu_zero` in 1: ALU zero flag for the current cycle's ALU operation.
- `mem_ready` in 1: memory completes the requested transfer this cycle.
- `mem_req` out 1: memory request; held until accepted.
- `mem_we` out 1: 1 = store, 0 = load/fetch.
- `ir_write` out 1: latch read data into the instruction register.
- `pc_write` out 1: update the PC.
- `pc_src` out 1: 0 = ALU result, 1 = ALUOUT register.
- `alu_src_a` out 2: 00 PC, 01 OLDPC, 10 RS1.
- `alu_src_b` out 2: 00 RS2, 01 const 4, 10 IMM.
- `alu_ctrl` out 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT.
- `imm_sel` out 2: 00 I, 01 S, 10 B, 11 J.
- `reg_write` out 1: write rd.
- `wb_sel` out 2: 00 ALUOUT, 01 MDR, 10 PC.
- `illegal` out 1: sticky trap flag.

## Operation
- States: RESET, FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- While `rst_n` is low: state = RESET, and all outputs are 0.
- Outputs are combinational from state plus `instr`. Any output not listed for a state is 0.
- RESET: goes to FETCH unconditionally on the first clock edge after `rst_n` rises.
- FETCH:
  - `mem_req`=1, `alu_src_a`=PC, `alu_src_b`=4, ADD.
  - On `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - ALU computes OLDPC+IMM (`alu_src_a`=01, `alu_src_b`=10, ADD).
  - `imm_sel` = B for branches, J for JAL, I otherwise.
  - Legal instruction → EXECUTE; otherwise → TRAP.
- Legal instructions:
  - R-type (opcode 0110011), funct7 0000000: funct3 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT.
  - R-type funct7 0100000 with funct3 000: SUB.
  - I-type ALU (0010011), funct3 000/111/110/100/010.
  - LW (0000011, funct3 010).
  - SW (0100011, funct3 010).
  - BEQ/BNE (1100011, funct3 000/001).
  - JAL (1101111).
- EXECUTE:
  - R-type: RS1 op RS2 → WB.
  - I-type: RS1 op IMM(I) → WB.
  - LW/SW: RS1+IMM (I or S) ADD → MEM.
  - Branch: RS1−RS2 SUB. If BEQ&&`alu_zero` or BNE&&!`alu_zero`: `pc_write`=1, `pc_src`=1. Next state FETCH.
  - JAL: `pc_write`=1, `pc_src`=1, `reg_write`=1, `wb_sel`=PC (the already-incremented PC). Next state FETCH.
- MEM:
  - `mem_req`=1, `mem_we` = SW; address is ALUOUT.
  - On `mem_ready`: LW → WB, SW → FETCH.
- WB: `reg_write`=1, `wb_sel` = MDR for LW, ALUOUT otherwise → FETCH.
- TRAP: `illegal`=1, all other outputs 0; exited only by reset.

## Timing
- Zero-wait memory cycle counts: R/I = 4, LW = 5, SW = 4, branch = 3, JAL = 3. Each cycle `mem_ready` is low in FETCH or MEM adds one cycle.
- Handshake rules:
  - A transfer completes on the edge where `mem_req`&&`mem_ready`.
  - `mem_we` and the selects stay stable while the request is pending.
  - `mem_ready` is ignored while `mem_req`=0.
- `alu_zero` is sampled in the same cycle as the SUB compare; there is no extra latency.
- Reset mid-transfer: state goes to RESET immediately and `mem_req` drops asynchronously. The in-flight access is abandoned.
- `illegal` asserts in the cycle after the DECODE of a bad encoding.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state enum;
  - opcode, funct3 and funct7 constants;
  - ALU control codes 000–101;
  - `alu_src_a`, `alu_src_b`, `pc_src`, `wb_sel` and `imm_sel` encodings.
- One sub-module, `instr_classify`, is combinational. It maps `instr` to a class (R, I, LW, SW, BR, JAL, BAD) plus the `alu_ctrl` value for R/I.
- The FSM owns only the state register.

## Test plan
- ADD x3,x1,x2 (0x002081B3), `mem_ready` always 1:
  - FETCH, DECODE, EXECUTE (`alu_ctrl`=000, src_a=10, src_b=00), WB (`reg_write`=1, `wb_sel`=00) → FETCH.
  - Total 4 cycles.
- LW x5,8(x1) (0x0080A283) with `mem_ready` low for 2 cycles in MEM:
  - `mem_req` held for 3 cycles with `mem_we`=0.
  - WB with `wb_sel`=01; total 7 cycles.
- BEQ (0x00208463):
  - `alu_zero`=1 → `pc_write`=1, `pc_src`=1 in EXECUTE.
  - `alu_zero`=0 → `pc_write`=0.
  - BNE (0x00209463) gives the opposite result in each case.
- JAL x1,+16 (0x010000EF):
  - DECODE: `imm_sel`=11.
  - EXECUTE: `reg_write`=1, `wb_sel`=10, `pc_write`=1, `pc_src`=1; 3 cycles total.
- Illegal: SLL (0x002091B3) and funct7 0x20 on AND (0x4020F1B3):
  - Both go to TRAP with `illegal`=1 and all other outputs 0, held for 20 cycles.
  - `rst_n` pulse → RESET → FETCH.
- Reset during a FETCH wait: `rst_n` low with `mem_req`=1 → `mem_req` 0 the same cycle, no `ir_write`, restart at FETCH.
